// File: rtl/cpu_pkg.sv
// Shared MIPS decode encodings: opcodes, functs, ALU/PC/writeback selects
// and the control bundle produced by the decoder.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_LUI = 4'd8
  } alu_op_e;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_BEQ  = 3'd1,
    PC_BNE  = 3'd2,
    PC_JUMP = 3'd3,
    PC_JR   = 3'd4
  } pc_ctrl_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC8 = 2'd2
  } wb_sel_e;

  // uses_rs/uses_rt mark which sources the instruction really reads,
  // so the load-use check does not stall on don't-care fields.
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr_reg;
    logic [31:0] imm;
    logic [4:0]  shamt;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        reg_wren;
    logic        mem_wren;
    logic        mem_rden;
    wb_sel_e     wb_sel;
    pc_ctrl_e    pc_ctrl;
    logic        illegal;
    logic        uses_rs;
    logic        uses_rt;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational MIPS instruction decoder: instruction word in,
// control bundle out.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Field extraction, per-opcode control, then illegal-encoding cleanup
  always_comb begin
    ctrl       = '0;
    ctrl.rs    = instr[25:21];
    ctrl.rt    = instr[20:16];
    ctrl.shamt = instr[10:6];
    ctrl.imm   = sext16(instr[15:0]);
    case (opcode)
      OP_RTYPE: begin
        ctrl.wr_reg   = instr[15:11];
        ctrl.reg_wren = 1'b1;
        ctrl.uses_rs  = 1'b1;
        ctrl.uses_rt  = 1'b1;
        case (funct)
          FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_XOR:  ctrl.alu_op = ALU_XOR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_SLL: begin
            ctrl.alu_op  = ALU_SLL;
            ctrl.uses_rs = 1'b0;
          end
          FN_SRL: begin
            ctrl.alu_op  = ALU_SRL;
            ctrl.uses_rs = 1'b0;
          end
          FN_JR: begin
            ctrl.reg_wren = 1'b0;
            ctrl.uses_rt  = 1'b0;
            ctrl.pc_ctrl  = PC_JR;
          end
          FN_JALR: begin
            ctrl.uses_rt = 1'b0;
            ctrl.pc_ctrl = PC_JR;
            ctrl.wb_sel  = WB_PC8;
          end
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        ctrl.wr_reg      = instr[20:16];
        ctrl.reg_wren    = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.uses_rs     = (opcode != OP_LUI);
        case (opcode)
          OP_SLTI: ctrl.alu_op = ALU_SLT;
          OP_ANDI: begin
            ctrl.alu_op = ALU_AND;
            ctrl.imm    = {16'h0000, instr[15:0]};
          end
          OP_ORI: begin
            ctrl.alu_op = ALU_OR;
            ctrl.imm    = {16'h0000, instr[15:0]};
          end
          OP_LUI: begin
            ctrl.alu_op = ALU_LUI;
            ctrl.imm    = {instr[15:0], 16'h0000};
          end
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ctrl.wr_reg      = instr[20:16];
        ctrl.reg_wren    = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_rden    = 1'b1;
        ctrl.wb_sel      = WB_MEM;
        ctrl.uses_rs     = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_wren    = 1'b1;
        ctrl.uses_rs     = 1'b1;
        ctrl.uses_rt     = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.pc_ctrl = (opcode == OP_BEQ) ? PC_BEQ : PC_BNE;
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      OP_J, OP_JAL: begin
        ctrl.imm     = {6'd0, instr[25:0]};
        ctrl.pc_ctrl = PC_JUMP;
        if (opcode == OP_JAL) begin
          ctrl.wr_reg   = 5'd31;
          ctrl.reg_wren = 1'b1;
          ctrl.wb_sel   = WB_PC8;
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase
    if (ctrl.illegal) begin
      ctrl.reg_wren = 1'b0;
      ctrl.mem_wren = 1'b0;
      ctrl.mem_rden = 1'b0;
      ctrl.pc_ctrl  = PC_SEQ;
      ctrl.uses_rs  = 1'b0;
      ctrl.uses_rt  = 1'b0;
    end
    if (!ctrl.reg_wren) ctrl.wr_reg = 5'd0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction queue from fetch, combinational decode of the
// head, load-use stall, and a registered output bundle to execute.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_load_rt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_wr_reg,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_shamt,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_src_imm,
  output logic            out_reg_wren,
  output logic            out_mem_wren,
  output logic            out_mem_rden,
  output logic [1:0]      out_wb_sel,
  output logic [2:0]      out_pc_ctrl,
  output logic            out_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]     instr_q [DEPTH];
  logic [PC_W-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic  full, empty, push, load, hazard;
  ctrl_t head_ctrl, out_ctrl;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;

  instr_decode u_decode (
    .instr (instr_q[rd_ptr]),
    .ctrl  (head_ctrl)
  );

  assign hazard = ex_load_valid && (ex_load_rt != 5'd0) &&
                  ((head_ctrl.uses_rs && (head_ctrl.rs == ex_load_rt)) ||
                   (head_ctrl.uses_rt && (head_ctrl.rt == ex_load_rt)));

  assign load = !empty && (!out_valid || out_ready) && !hazard && !flush;

  // Queue storage: written on push, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= in_instr;
      pc_q[wr_ptr]    <= in_pc;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output register: load decoded head, drop valid after handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_ctrl  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_pc    <= pc_q[rd_ptr];
      out_ctrl  <= head_ctrl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_rs          = out_ctrl.rs;
  assign out_rt          = out_ctrl.rt;
  assign out_wr_reg      = out_ctrl.wr_reg;
  assign out_imm         = out_ctrl.imm;
  assign out_shamt       = out_ctrl.shamt;
  assign out_alu_op      = out_ctrl.alu_op;
  assign out_alu_src_imm = out_ctrl.alu_src_imm;
  assign out_reg_wren    = out_ctrl.reg_wren;
  assign out_mem_wren    = out_ctrl.mem_wren;
  assign out_mem_rden    = out_ctrl.mem_rden;
  assign out_wb_sel      = out_ctrl.wb_sel;
  assign out_pc_ctrl     = out_ctrl.pc_ctrl;
  assign out_illegal     = out_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rt;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs, out_rt, out_wr_reg, out_shamt;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_op;
  logic        out_alu_src_imm, out_reg_wren, out_mem_wren, out_mem_rden;
  logic [1:0]  out_wb_sel;
  logic [2:0]  out_pc_ctrl;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  decode_stage #(.PC_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .ex_load_valid(ex_load_valid), .ex_load_rt(ex_load_rt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs(out_rs), .out_rt(out_rt), .out_wr_reg(out_wr_reg), .out_imm(out_imm),
    .out_shamt(out_shamt), .out_alu_op(out_alu_op), .out_alu_src_imm(out_alu_src_imm),
    .out_reg_wren(out_reg_wren), .out_mem_wren(out_mem_wren), .out_mem_rden(out_mem_rden),
    .out_wb_sel(out_wb_sel), .out_pc_ctrl(out_pc_ctrl), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  // Push one instruction into an empty stage with out_ready=1 and wait one
  // more edge so the decoded bundle is on the outputs.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    out_ready = 1'b1;
    push(instr, pc);
    step();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    ex_load_valid = 1'b0; ex_load_rt = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_out_wr_reg", {27'd0, out_wr_reg}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADDU $2,$4,$5: one edge to push, one to load
    out_ready = 1'b1;
    push(32'h00851021, 32'h0000_0100);
    chk("addu_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    chk("addu_valid", {31'd0, out_valid}, 32'd1);
    chk("addu_wr_reg", {27'd0, out_wr_reg}, 32'd2);
    chk("addu_wren", {31'd0, out_reg_wren}, 32'd1);
    chk("addu_src_imm", {31'd0, out_alu_src_imm}, 32'd0);
    chk("addu_pc", out_pc, 32'h0000_0100);
    chk("addu_rs_rt", {22'd0, out_rs, out_rt}, {22'd0, 5'd4, 5'd5});
    step();
    chk("addu_drained", {31'd0, out_valid}, 32'd0);

    // Immediate extension
    issue(32'h30238000, 32'h0000_0200);
    chk("andi_imm", out_imm, 32'h0000_8000);
    chk("andi_wr_reg", {27'd0, out_wr_reg}, 32'd3);
    issue(32'h24238000, 32'h0000_0204);
    chk("addiu_imm", out_imm, 32'hFFFF_8000);
    issue(32'h3C031234, 32'h0000_0208);
    chk("lui_imm", out_imm, 32'h1234_0000);

    // Memory, branch, jump, shift decodes
    issue(32'h8CE60004, 32'h0000_0300);
    chk("lw_ctrl", {26'd0, out_mem_rden, out_mem_wren, out_wb_sel, out_alu_src_imm, out_reg_wren},
        {26'd0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1});
    chk("lw_wr_reg", {27'd0, out_wr_reg}, 32'd6);
    issue(32'hACE60004, 32'h0000_0304);
    chk("sw_ctrl", {26'd0, out_mem_rden, out_mem_wren, out_reg_wren, out_wr_reg[2:0]},
        {26'd0, 1'b0, 1'b1, 1'b0, 3'd0});
    issue(32'h1422FFFF, 32'h0000_0308);
    chk("bne_ctrl", {28'd0, out_pc_ctrl, out_reg_wren}, {28'd0, 3'd2, 1'b0});
    chk("bne_imm", out_imm, 32'hFFFF_FFFF);
    issue(32'h0C000010, 32'h0000_030C);
    chk("jal_ctrl", {22'd0, out_pc_ctrl, out_wb_sel, out_wr_reg},
        {22'd0, 3'd3, 2'd2, 5'd31});
    chk("jal_imm", out_imm, 32'h0000_0010);
    issue(32'h00031100, 32'h0000_0310);
    chk("sll_ctrl", {18'd0, out_alu_op, out_shamt, out_wr_reg},
        {18'd0, 4'd6, 5'd4, 5'd2});

    // Illegal encodings still flow with side effects suppressed
    issue(32'hFC000000, 32'h0000_0400);
    chk("ill_op", {27'd0, out_valid, out_illegal, out_reg_wren, out_mem_wren, out_mem_rden},
        {27'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("ill_pc_ctrl", {29'd0, out_pc_ctrl}, 32'd0);
    issue(32'h0000003F, 32'h0000_0404);
    chk("ill_funct", {30'd0, out_illegal, out_reg_wren}, {30'd0, 1'b1, 1'b0});
    step();

    // Fill: 1 staged + 4 queued, then drain in order
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("fill_in_ready", {31'd0, in_ready}, 32'd1);
      push(32'h00851021, 32'h0000_1000 + 32'(4 * k));
    end
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("hold_pc", out_pc, 32'h0000_1000);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_pc", out_pc, 32'h0000_1000 + 32'(4 * k));
      step();
    end
    chk("drain_done", {31'd0, out_valid}, 32'd0);

    // Load-use hazard on rs=4
    ex_load_valid = 1'b1;
    ex_load_rt    = 5'd4;
    push(32'h00851021, 32'h0000_2000);
    step();
    chk("haz_bubble1", {31'd0, out_valid}, 32'd0);
    step();
    chk("haz_bubble2", {31'd0, out_valid}, 32'd0);
    ex_load_valid = 1'b0;
    step();
    chk("haz_release", {31'd0, out_valid}, 32'd1);
    chk("haz_pc", out_pc, 32'h0000_2000);
    step();
    // LUI reads no source: no stall even when rt matches
    ex_load_valid = 1'b1;
    ex_load_rt    = 5'd3;
    issue(32'h3C031234, 32'h0000_2004);
    chk("lui_no_haz", {31'd0, out_valid}, 32'd1);
    ex_load_valid = 1'b0;
    step();

    // Flush with 1 staged + 3 queued and a simultaneous push
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(32'h00851021, 32'h0000_3000 + 32'(4 * k));
    chk("pre_flush_valid", {31'd0, out_valid}, 32'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h24238000;
    in_pc    = 32'h0000_3FFF;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step(); step();
    chk("flush_empty", {31'd0, out_valid}, 32'd0);
    issue(32'h30238000, 32'h0000_3100);
    chk("post_flush_pc", out_pc, 32'h0000_3100);
    step();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    push(32'h00851021, 32'h0000_5000);
    push(32'h00851021, 32'h0000_5004);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step(); step();
    chk("arst_empty", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
